// File: rtl/pwd_access_pkg.sv
// rtl/pwd_access_pkg.sv - shared state encoding and response codes for the password front-end
package pwd_access_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP,
        ST_LOCKED
    } state_t;

    localparam logic [1:0] RSP_OK      = 2'b00;
    localparam logic [1:0] RSP_BAD_PWD = 2'b01;
    localparam logic [1:0] RSP_ROM_WP  = 2'b10;
    localparam logic [1:0] RSP_LOCKED  = 2'b11;

    // Failure counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [3:0] sat_inc(input logic [3:0] value);
        return (value == 4'hF) ? value : value + 4'd1;
    endfunction

endpackage

// File: rtl/lockout_timer.sv
// rtl/lockout_timer.sv - loadable down-counter that times the lockout window
module lockout_timer #(
    parameter int LOCK_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic run,
    output logic expire
);

    localparam logic [15:0] LOAD_VAL = 16'(LOCK_CYCLES);

    logic [15:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 16'd0;
        end else if (load) begin
            count <= LOAD_VAL;
        end else if (run && count != 16'd0) begin
            count <= count - 16'd1;
        end
    end

    // Treat 0 like 1 so a stray run with an unloaded timer can never stall in LOCKED.
    assign expire = run && (count <= 16'd1);

endmodule

// File: rtl/password_access_ctrl.sv
// rtl/password_access_ctrl.sv - authenticates password+command requests and strobes storage
module password_access_ctrl
    import pwd_access_pkg::*;
#(
    parameter logic [7:0] RAM_PWD     = 8'hBF,
    parameter logic [7:0] ROM_PWD     = 8'h3E,
    parameter int         MAX_FAILS   = 3,
    parameter int         LOCK_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_pwd,
    input  logic       req_write,
    input  logic [7:0] req_wdata,
    input  logic       prog_en,
    output logic       rsp_valid,
    output logic [1:0] rsp_code,
    output logic [7:0] rsp_rdata,
    output logic       locked,
    output logic [7:0] mem_pwd,
    output logic [7:0] mem_wdata,
    output logic       mem_wr_en,
    output logic       mem_rd_en,
    input  logic [7:0] mem_rdata
);

    localparam logic [3:0] MAX_F = 4'(MAX_FAILS);

    state_t      state;
    state_t      next_state;
    logic [7:0]  pwd_q;
    logic [7:0]  wdata_q;
    logic        write_q;
    logic [3:0]  fail_cnt;
    logic [3:0]  fail_inc;
    logic        lock_pending;
    logic        ram_hit;
    logic        rom_hit;
    logic        grant;
    logic [1:0]  check_code;
    logic        timer_expire;
    logic        to_mem_phase;

    lockout_timer #(
        .LOCK_CYCLES(LOCK_CYCLES)
    ) u_lockout_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (state == ST_RESP && lock_pending),
        .run    (state == ST_LOCKED),
        .expire (timer_expire)
    );

    // Authentication decision, only consumed while in CHECK.
    always_comb begin
        ram_hit    = (pwd_q == RAM_PWD);
        rom_hit    = (pwd_q == ROM_PWD);
        grant      = ram_hit || (rom_hit && (!write_q || prog_en));
        fail_inc   = sat_inc(fail_cnt);
        check_code = RSP_OK;
        if (grant) begin
            check_code = RSP_OK;
        end else if (rom_hit) begin
            check_code = RSP_ROM_WP;
        end else if (fail_inc >= MAX_F) begin
            check_code = RSP_LOCKED;
        end else begin
            check_code = RSP_BAD_PWD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (req_valid) next_state = ST_CHECK;
            ST_CHECK:  next_state = grant ? ST_ISSUE : ST_RESP;
            ST_ISSUE:  next_state = ST_WAIT;
            ST_WAIT:   next_state = ST_RESP;
            ST_RESP:   next_state = lock_pending ? ST_LOCKED : ST_IDLE;
            ST_LOCKED: if (timer_expire) next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pwd_q        <= 8'h00;
            wdata_q      <= 8'h00;
            write_q      <= 1'b0;
            fail_cnt     <= 4'd0;
            lock_pending <= 1'b0;
        end else begin
            if (state == ST_IDLE && req_valid) begin
                pwd_q   <= req_pwd;
                wdata_q <= req_wdata;
                write_q <= req_write;
            end
            // ROM write-protect denials leave the failure count untouched.
            if (state == ST_CHECK) begin
                if (grant) begin
                    fail_cnt <= 4'd0;
                end else if (!rom_hit) begin
                    fail_cnt <= fail_inc;
                    if (fail_inc >= MAX_F) lock_pending <= 1'b1;
                end
            end
            if (state == ST_LOCKED && timer_expire) begin
                fail_cnt     <= 4'd0;
                lock_pending <= 1'b0;
            end
        end
    end

    // Outputs are registered from next_state so each one lines up with the state it describes.
    assign to_mem_phase = (next_state == ST_ISSUE) || (next_state == ST_WAIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            req_ready <= 1'b1;
            locked    <= 1'b0;
            mem_wr_en <= 1'b0;
            mem_rd_en <= 1'b0;
            mem_pwd   <= 8'h00;
            mem_wdata <= 8'h00;
            rsp_valid <= 1'b0;
            rsp_code  <= RSP_OK;
            rsp_rdata <= 8'h00;
        end else begin
            req_ready <= (next_state == ST_IDLE);
            locked    <= (next_state == ST_LOCKED);
            mem_wr_en <= (next_state == ST_ISSUE) && write_q;
            mem_rd_en <= (next_state == ST_ISSUE) && !write_q;
            mem_pwd   <= to_mem_phase ? pwd_q : 8'h00;
            mem_wdata <= (to_mem_phase && write_q) ? wdata_q : 8'h00;
            rsp_valid <= (next_state == ST_RESP);
            if (next_state == ST_RESP) begin
                rsp_code <= (state == ST_CHECK) ? check_code : RSP_OK;
            end else begin
                rsp_code <= RSP_OK;
            end
            rsp_rdata <= (state == ST_WAIT && !write_q) ? mem_rdata : 8'h00;
        end
    end

endmodule
